// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage hazard bundle between the pipeline and the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
   parameter int NREG   = 32,
   parameter int NSTAGE = 3,
   parameter int TW     = 2,
   parameter int CNT_W  = 16
);
   localparam int AW = $clog2(NREG);
   localparam int FW = $clog2(NSTAGE + 1);

   logic                   id_valid;
   logic [AW-1:0]          id_a1;
   logic [AW-1:0]          id_a2;
   logic [TW-1:0]          id_t_use1;
   logic [TW-1:0]          id_t_use2;
   logic [AW-1:0]          id_a3;
   logic [TW-1:0]          id_t_new;
   logic                   id_md;
   logic                   id_eret;
   logic                   id_mtc0_epc;
   logic                   md_busy;
   logic                   md_start;
   logic                   flush;
   logic [NSTAGE*AW-1:0]   stage_a3;
   logic                   stall;
   logic                   enable_pc;
   logic                   enable_if_id;
   logic                   flush_id_ex;
   logic [FW-1:0]          fwd_sel1;
   logic [FW-1:0]          fwd_sel2;
   logic [CNT_W-1:0]       perf_stall;
   logic [CNT_W-1:0]       perf_md_stall;

   modport master (
      output id_valid, id_a1, id_a2, id_t_use1, id_t_use2, id_a3, id_t_new,
             id_md, id_eret, id_mtc0_epc, md_busy, md_start, flush, stage_a3,
      input  stall, enable_pc, enable_if_id, flush_id_ex, fwd_sel1, fwd_sel2,
             perf_stall, perf_md_stall
   );

   modport slave (
      input  id_valid, id_a1, id_a2, id_t_use1, id_t_use2, id_a3, id_t_new,
             id_md, id_eret, id_mtc0_epc, md_busy, md_start, flush, stage_a3,
      output stall, enable_pc, enable_if_id, flush_id_ex, fwd_sel1, fwd_sel2,
             perf_stall, perf_md_stall
   );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Pending-write scoreboard hazard unit with forwarding selects,
//            mult/div and mtc0-EPC/eret interlocks. Optional stall counters
//            are enabled with the HAZARD_PERF_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int NREG    = 32,
   parameter int NSTAGE  = 3,
   parameter int TW      = 2,
   parameter int EPC_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   hazard_scoreboard_if.slave hz
);
   localparam int AW = $clog2(NREG);
   localparam int FW = $clog2(NSTAGE + 1);
   localparam int EW = (EPC_LAT < 1) ? 1 : $clog2(EPC_LAT + 1);

   logic [TW-1:0] cnt_q [NREG];
   logic [TW-1:0] cnt_d [NREG];
   logic [EW-1:0] epc_pend_q;
   logic [EW-1:0] epc_pend_d;

   logic w_data_haz;
   logic w_md_haz;
   logic w_epc_haz;
   logic w_stall;
   logic w_issue;
   logic [FW-1:0] w_fwd1;
   logic [FW-1:0] w_fwd2;

   // Hazard terms look only at registered countdowns, never at this cycle's issue.
   always_comb begin
      w_data_haz = ((hz.id_a1 != '0) && (cnt_q[hz.id_a1] > hz.id_t_use1)) ||
                   ((hz.id_a2 != '0) && (cnt_q[hz.id_a2] > hz.id_t_use2));
      w_md_haz   = hz.id_md && (hz.md_busy || hz.md_start);
      w_epc_haz  = hz.id_eret && (epc_pend_q != '0);
      w_stall    = hz.id_valid && (w_data_haz || w_md_haz || w_epc_haz) && !hz.flush;
      w_issue    = hz.id_valid && !w_stall && !hz.flush;
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - TW'(1) : cnt_q[i];
         if (hz.flush) begin
            cnt_d[i] = '0;
         end else if (w_issue && (hz.id_a3 != '0) && (int'(hz.id_a3) == i)) begin
            cnt_d[i] = hz.id_t_new;
         end
      end
   end

   always_comb begin
      epc_pend_d = (epc_pend_q != '0) ? epc_pend_q - EW'(1) : epc_pend_q;
      if (hz.flush) begin
         epc_pend_d = '0;
      end else if (w_issue && hz.id_mtc0_epc) begin
         epc_pend_d = EW'(EPC_LAT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         epc_pend_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         epc_pend_q <= epc_pend_d;
      end
   end

   // Scan oldest to youngest so the youngest matching producer is left standing.
   always_comb begin
      w_fwd1 = '0;
      w_fwd2 = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if ((hz.id_a1 != '0) && (hz.stage_a3[(k-1)*AW +: AW] == hz.id_a1)) begin
            w_fwd1 = FW'(k);
         end
         if ((hz.id_a2 != '0) && (hz.stage_a3[(k-1)*AW +: AW] == hz.id_a2)) begin
            w_fwd2 = FW'(k);
         end
      end
   end

   assign hz.stall        = w_stall;
   assign hz.enable_pc    = !w_stall;
   assign hz.enable_if_id = !w_stall;
   assign hz.flush_id_ex  = w_stall;
   assign hz.fwd_sel1     = w_fwd1;
   assign hz.fwd_sel2     = w_fwd2;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] perf_stall_q;
   logic [CNT_W-1:0] perf_stall_d;
   logic [CNT_W-1:0] perf_md_stall_q;
   logic [CNT_W-1:0] perf_md_stall_d;

   // Counters wrap naturally at 2^CNT_W.
   always_comb begin
      perf_stall_d    = perf_stall_q;
      perf_md_stall_d = perf_md_stall_q;
      if (w_stall) begin
         perf_stall_d = perf_stall_q + CNT_W'(1);
         if (w_md_haz) begin
            perf_md_stall_d = perf_md_stall_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q    <= '0;
         perf_md_stall_q <= '0;
      end else begin
         perf_stall_q    <= perf_stall_d;
         perf_md_stall_q <= perf_md_stall_d;
      end
   end

   assign hz.perf_stall    = perf_stall_q;
   assign hz.perf_md_stall = perf_md_stall_q;
`else
   assign hz.perf_stall    = {CNT_W{1'b0}};
   assign hz.perf_md_stall = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Scoreboard-driven self-checking bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
   localparam int NREG    = 32;
   localparam int NSTAGE  = 3;
   localparam int TW      = 2;
   localparam int EPC_LAT = 2;
   localparam int CNT_W   = 16;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] fwd1;
      logic [1:0] fwd2;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t exp_q[$];
   exp_t mon_e;
`ifdef HAZARD_PERF_EN
   localparam logic [CNT_W-1:0] EXP_PERF_ALL = 16'd9;
   localparam logic [CNT_W-1:0] EXP_PERF_MD  = 16'd5;
`else
   localparam logic [CNT_W-1:0] EXP_PERF_ALL = 16'd0;
   localparam logic [CNT_W-1:0] EXP_PERF_MD  = 16'd0;
`endif

   hazard_scoreboard_if #(.NREG(NREG), .NSTAGE(NSTAGE), .TW(TW), .CNT_W(CNT_W)) hz ();

   hazard_scoreboard #(
      .NREG(NREG), .NSTAGE(NSTAGE), .TW(TW), .EPC_LAT(EPC_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, half a cycle after inputs settle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk({mon_e.tag, ".stall"}, 32'(hz.stall), 32'(mon_e.stall));
         chk({mon_e.tag, ".en_pc"}, 32'(hz.enable_pc), 32'(!mon_e.stall));
         chk({mon_e.tag, ".en_ifid"}, 32'(hz.enable_if_id), 32'(!mon_e.stall));
         chk({mon_e.tag, ".flush_idex"}, 32'(hz.flush_id_ex), 32'(mon_e.stall));
         chk({mon_e.tag, ".fwd1"}, 32'(hz.fwd_sel1), 32'(mon_e.fwd1));
         chk({mon_e.tag, ".fwd2"}, 32'(hz.fwd_sel2), 32'(mon_e.fwd2));
      end
   end

   task automatic cyc(input string tag, input logic st,
                      input logic [1:0] f1 = 2'd0, input logic [1:0] f2 = 2'd0);
      exp_q.push_back('{tag, st, f1, f2});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.id_valid    = 1'b0;
      hz.id_a1       = '0;
      hz.id_a2       = '0;
      hz.id_t_use1   = '0;
      hz.id_t_use2   = '0;
      hz.id_a3       = '0;
      hz.id_t_new    = '0;
      hz.id_md       = 1'b0;
      hz.id_eret     = 1'b0;
      hz.id_mtc0_epc = 1'b0;
      hz.md_busy     = 1'b0;
      hz.md_start    = 1'b0;
      hz.flush       = 1'b0;
      hz.stage_a3    = '0;
   endtask

   task automatic ins(input int a1, input int tu1, input int a2, input int tu2,
                      input int a3, input int tnew);
      hz.id_valid    = 1'b1;
      hz.id_a1       = 5'(a1);
      hz.id_t_use1   = 2'(tu1);
      hz.id_a2       = 5'(a2);
      hz.id_t_use2   = 2'(tu2);
      hz.id_a3       = 5'(a3);
      hz.id_t_new    = 2'(tnew);
      hz.id_md       = 1'b0;
      hz.id_eret     = 1'b0;
      hz.id_mtc0_epc = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      @(posedge clk);
      #1;
      cyc("rst", 1'b0);
      rst_n = 1'b1;

      // load-use: lw $8 then dependent add
      ins(0, 0, 0, 0, 8, 2);  cyc("lw8", 1'b0);
      ins(8, 0, 0, 0, 10, 1); cyc("add_s1", 1'b1);
      cyc("add_s2", 1'b1);
      hz.stage_a3 = {5'd0, 5'd8, 5'd0};
      cyc("add_go", 1'b0, 2'd2, 2'd0);
      hz.stage_a3 = '0;

      ins(0, 0, 0, 0, 9, 1);  cyc("addu9", 1'b0);
      ins(9, 0, 0, 0, 0, 0);  cyc("beq_s", 1'b1);
      cyc("beq_go", 1'b0);
      ins(0, 0, 0, 0, 9, 1);  cyc("addu9b", 1'b0);
      ins(29, 1, 9, 2, 0, 0); cyc("sw", 1'b0);

      // countdown equal to t_use must not stall; one less slack must
      ins(0, 0, 0, 0, 7, 2);  cyc("lw7", 1'b0);
      ins(0, 0, 7, 2, 11, 1); cyc("eq_bound", 1'b0);
      ins(7, 0, 0, 0, 0, 0);  cyc("a1_7", 1'b1);
      cyc("a1_7_go", 1'b0);

      ins(0, 0, 0, 0, 6, 3);  cyc("lw6", 1'b0);
      ins(6, 0, 0, 0, 0, 0);
      hz.id_valid = 1'b0;     cyc("inval", 1'b0);
      ins(0, 0, 0, 0, 0, 3);  cyc("a3_zero", 1'b0);
      ins(0, 0, 0, 0, 0, 0);  cyc("r0", 1'b0);

      idle();
      hz.stage_a3 = {5'd3, 5'd3, 5'd5};
      hz.id_a1 = 5'd3; hz.id_a2 = 5'd5; cyc("fwd_a", 1'b0, 2'd2, 2'd1);
      hz.id_a1 = 5'd0; hz.id_a2 = 5'd3; cyc("fwd_b", 1'b0, 2'd0, 2'd2);
      hz.stage_a3 = {5'd3, 5'd0, 5'd0};
      hz.id_a1 = 5'd3; hz.id_a2 = 5'd4; cyc("fwd_c", 1'b0, 2'd3, 2'd0);
      idle();

      ins(0, 0, 0, 0, 0, 0);
      hz.id_md = 1'b1; hz.md_busy = 1'b1;
      for (int i = 0; i < 5; i++) cyc("md_busy", 1'b1);
      hz.md_busy = 1'b0;      cyc("md_go", 1'b0);
      chk("perf_stall", 32'(hz.perf_stall), 32'(EXP_PERF_ALL));
      chk("perf_md_stall", 32'(hz.perf_md_stall), 32'(EXP_PERF_MD));
      hz.md_start = 1'b1;     cyc("md_start", 1'b1);
      hz.md_start = 1'b0;     cyc("md_start_go", 1'b0);
      hz.id_md = 1'b0; hz.md_busy = 1'b1; cyc("md_nodep", 1'b0);
      hz.md_busy = 1'b0;

      ins(0, 0, 0, 0, 0, 0);
      hz.id_mtc0_epc = 1'b1;  cyc("mtc0", 1'b0);
      hz.id_mtc0_epc = 1'b0;
      hz.id_eret = 1'b1;      cyc("eret_s1", 1'b1);
      cyc("eret_s2", 1'b1);
      cyc("eret_go", 1'b0);

      // flush wipes pending writes and refuses the co-issued load
      ins(0, 0, 0, 0, 8, 2);  cyc("lw8f", 1'b0);
      ins(8, 0, 0, 0, 12, 2);
      hz.flush = 1'b1;        cyc("flush", 1'b0);
      hz.flush = 1'b0;
      ins(8, 0, 12, 0, 0, 0); cyc("post_flush", 1'b0);
      ins(0, 0, 0, 0, 0, 0);
      hz.id_mtc0_epc = 1'b1;  cyc("mtc0f", 1'b0);
      idle();
      hz.flush = 1'b1;        cyc("flush2", 1'b0);
      hz.flush = 1'b0;
      ins(0, 0, 0, 0, 0, 0);
      hz.id_eret = 1'b1;      cyc("eret_after_flush", 1'b0);

      ins(0, 0, 0, 0, 8, 3);  cyc("lw8r", 1'b0);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      ins(8, 0, 0, 0, 0, 0);  cyc("post_arst", 1'b0);
      chk("perf_after_arst", 32'(hz.perf_stall), 32'd0);

      idle();
      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
